// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared types and constants for the core-to-memory-bus bridge.
//   - bridge_state_e : bridge FSM states
//   - WORD_ALIGN_MASK: low address bits that must be zero for a word access
//   - err_cause_e    : why an access completed with an error (kept for debug)
//   - is_misaligned  : helper that applies WORD_ALIGN_MASK to an address
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } bridge_state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_cause_e;

    // A word access is misaligned when any of the masked low address bits is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_bridge_wdog.sv
// mem_bridge_wdog
//   Watchdog counter for the memory bridge. Counts the cycles for which
//   'enable' is high since the last 'clear'. 'expired' is raised during the
//   TIMEOUT-th enabled cycle, so the bridge leaves its wait states exactly
//   TIMEOUT cycles after it entered them.
//   Ports:
//     clk     in  system clock, rising edge
//     reset   in  synchronous, active-high
//     clear   in  restart the count (new access accepted)
//     enable  in  bridge is waiting on the bus this cycle
//     expired out limit reached this cycle
module mem_bridge_wdog
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Expiry is flagged on the last allowed waiting cycle rather than one
    // cycle later, so the bridge reaches DONE exactly TIMEOUT cycles after
    // it started waiting.
    assign expired = enable && (count_q == LAST_COUNT);

    // The count holds once expired; the next acceptance clears it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge
//   Bridges the multi-cycle core's shared memory port (fetch/load/store) to a
//   variable-latency bus with request/grant and read-valid handshakes. Each
//   accepted access is latched, driven on the bus until completion, and
//   signalled back with a one-cycle core_done. Read data is held in
//   core_rdata until the next successful read.
//   Optional feature: define MEM_BRIDGE_TIMEOUT_EN to add a watchdog that
//   aborts an access with core_err after TIMEOUT cycles of waiting.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     core_req/we/addr/wdata     core access request (sampled when core_ready)
//     core_ready                 bridge idle, request accepted this cycle
//     core_stall                 access in flight on the bus
//     core_done/core_err         completion pulse and its error flag
//     core_rdata                 last successful read data, held
//     mem_req/we/addr/wdata      bus request side
//     mem_gnt                    bus accepted the request this cycle
//     mem_rvalid/mem_rdata       bus read response
module mem_bridge
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEM_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ready,
    output logic              core_stall,
    output logic              core_done,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    bridge_state_e     state_d,     state_q;
    logic              we_d,        we_q;
    logic [ADDR_W-1:0] addr_d,      addr_q;
    logic [DATA_W-1:0] wdata_d,     wdata_q;
    logic [DATA_W-1:0] rdata_d,     rdata_q;
    err_cause_e        err_cause_d, err_cause_q;
    logic              wdog_expired;

    // Every output is either a latch or a decode of the current state, so
    // the core and the bus never see a combinational path through the bridge.
    assign core_ready = (state_q == ST_IDLE);
    assign core_stall = (state_q == ST_REQ) || (state_q == ST_RDWAIT);
    assign core_done  = (state_q == ST_DONE);
    assign core_err   = (state_q == ST_DONE) && (err_cause_q != ERR_NONE);
    assign core_rdata = rdata_q;
    assign mem_req    = (state_q == ST_REQ);
    assign mem_we     = (state_q == ST_REQ) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // The watchdog restarts on every accepted access and only counts while
    // the bridge is actually waiting on the bus.
    logic wdog_clear;
    assign wdog_clear = core_ready && core_req;

    mem_bridge_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (core_stall),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    // Next-state and latch logic. Requests are only looked at in IDLE, grant
    // only in REQ and read-valid only in RDWAIT, so stray handshakes are
    // simply dropped. A grant or read-valid that lands on the same cycle as
    // a watchdog expiry wins, since the bus has already acted on it.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_cause_d = err_cause_q;

        unique case (state_q)
            ST_IDLE: begin
                if (core_req) begin
                    we_d    = core_we;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    if (is_misaligned(core_addr[1:0])) begin
                        err_cause_d = ERR_MISALIGN;
                        state_d     = ST_DONE;
                    end else begin
                        err_cause_d = ERR_NONE;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? ST_DONE : ST_RDWAIT;
                end else if (wdog_expired) begin
                    err_cause_d = ERR_TIMEOUT;
                    state_d     = ST_DONE;
                end
            end
            ST_RDWAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (wdog_expired) begin
                    err_cause_d = ERR_TIMEOUT;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight access; the bus side must be reset too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_cause_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_cause_q <= err_cause_d;
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
//   Self-checking bench for mem_bridge. Inputs are driven and outputs are
//   observed on the falling clock edge. Each access is described by its
//   bus latencies; the expected completion cycle, stall length, request
//   length, error flag and held read data follow from those latencies with
//   plain arithmetic.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ready;
    logic        core_stall;
    logic        core_done;
    logic        core_err;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] modelRdata  = 32'h0;

    always #5 clk = ~clk;

    mem_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ready (core_ready),
        .core_stall (core_stall),
        .core_done  (core_done),
        .core_err   (core_err),
        .core_rdata (core_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // One comparison: counts it, and counts and reports it when it misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one complete core access. gntDelay is the number of REQ cycles
    // with grant low before grant; rvDelay is how many cycles after grant
    // the read data arrives (at least 1). holdReq keeps core_req high for
    // the whole access. Core inputs are scrambled after acceptance and stray
    // handshakes are thrown at the bridge where they must be ignored.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int gntDelay,
                                 input int rvDelay, input logic [31:0] rdData,
                                 input logic holdReq);
        logic mis;
        logic errSeen;
        int   expDone, expStall, expReq;
        int   n, doneAt, stallCnt, reqCnt, readyCnt, busBad;

        mis      = (addr[1:0] != 2'b00);
        expDone  = mis ? 1 : (we ? 2 + gntDelay : 2 + gntDelay + rvDelay);
        expStall = mis ? 0 : (we ? gntDelay + 1 : gntDelay + rvDelay + 1);
        expReq   = mis ? 0 : gntDelay + 1;
        if (!we && !mis) modelRdata = rdData;

        @(negedge clk);
        checkOutput("ready_before_accept", 32'(core_ready), 32'd1);
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;

        n = 0; doneAt = 0; stallCnt = 0; reqCnt = 0; readyCnt = 0; busBad = 0;
        errSeen = 1'b0;
        while (doneAt == 0 && n < 64) begin
            @(negedge clk);
            n++;
            if (core_stall) stallCnt++;
            if (core_ready) readyCnt++;
            if (mem_req) begin
                reqCnt++;
                if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) busBad++;
            end
            if (core_done) begin
                doneAt  = n;
                errSeen = core_err;
                checkOutput("rdata_at_done", core_rdata, modelRdata);
            end
            core_req   = holdReq;
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = $urandom;
            core_wdata = $urandom;
            mem_gnt    = !mis && (n == 1 + gntDelay);
            if (!we && !mis && n == 1 + gntDelay + rvDelay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdData;
            end else if (n <= 1 + gntDelay) begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            if (!mis && n > 1 + gntDelay && n < 1 + gntDelay + rvDelay) begin
                mem_gnt = 1'($urandom_range(0, 1));
            end
        end
        core_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;

        checkOutput("done_cycle", 32'(doneAt), 32'(expDone));
        checkOutput("err_flag", 32'(errSeen), 32'(mis));
        checkOutput("stall_cycles", 32'(stallCnt), 32'(expStall));
        checkOutput("req_cycles", 32'(reqCnt), 32'(expReq));
        checkOutput("ready_while_busy", 32'(readyCnt), 32'd0);
        checkOutput("bus_fields_stable", 32'(busBad), 32'd0);

        @(negedge clk);
        checkOutput("done_single_pulse", 32'(core_done), 32'd0);
        checkOutput("ready_after_done", 32'(core_ready), 32'd1);
        checkOutput("rdata_held", core_rdata, modelRdata);
    endtask

    initial begin
        logic        rWe;
        logic [31:0] rAddr;

        reset      = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(core_ready), 32'd1);
        checkOutput("rst_stall", 32'(core_stall), 32'd0);
        checkOutput("rst_done", 32'(core_done), 32'd0);
        checkOutput("rst_err", 32'(core_err), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_rdata", core_rdata, 32'h0);
        reset = 1'b0;

        // Read, immediate grant, data three cycles later.
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 3, 32'hDEAD_BEEF, 1'b0);
        // Write with grant held low for two cycles.
        applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 2, 1, 32'h0, 1'b0);
        // Misaligned access never reaches the bus.
        applyStimulus(1'b0, 32'h0000_0022, 32'h0, 0, 1, 32'h0, 1'b0);
        // Request held high across a read, then a second access.
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 1, 2, 32'hCAFE_F00D, 1'b1);
        applyStimulus(1'b1, 32'h0000_0034, 32'hA5A5_5A5A, 0, 1, 32'h0, 1'b0);
        // Fastest read: grant at once, data the next cycle.
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0);

        // Randomised accesses, roughly a quarter misaligned.
        for (int i = 0; i < 12; i++) begin
            rWe   = 1'($urandom_range(0, 1));
            rAddr = $urandom;
            if ($urandom_range(0, 3) != 0) rAddr[1:0] = 2'b00;
            applyStimulus(rWe, rAddr, $urandom, $urandom_range(0, 3),
                          $urandom_range(1, 3), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(negedge clk);
        core_req   = 1'b1;
        core_we    = 1'b0;
        core_addr  = 32'h0000_0040;
        @(negedge clk);
        core_req   = 1'b0;
        mem_gnt    = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        checkOutput("rdwait_stall", 32'(core_stall), 32'd1);
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        modelRdata = 32'h0;
        checkOutput("abort_ready", 32'(core_ready), 32'd1);
        checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort_done", 32'(core_done), 32'd0);
        checkOutput("abort_rdata", core_rdata, modelRdata);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_1111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("stray_rvalid_done", 32'(core_done), 32'd0);
        checkOutput("stray_rvalid_rdata", core_rdata, modelRdata);
        checkOutput("stray_rvalid_ready", 32'(core_ready), 32'd1);

        // The bridge is usable again after the abort.
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1, 1, 32'h1357_9BDF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
